line_clear_ctrl: RTL and testbench

LINE_CLEAR_CTRL -- requirements
Module: line_clear_ctrl

---
 rtl/line_clear_ctrl.sv | 145 ++++++++++++++
 tb/tb_line_clear_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl
//   Removes full rows from a falling-block game board. Each pass scans the
//   board from the bottom row up. When a full row is found, every row above
//   it moves down by one and the same row is checked again. At the end of
//   the pass the compacted board, the number of rows removed and an updated
//   score are published.
//
//   Optional feature macro: LINE_CLEAR_BONUS_EN
//     defined   -> score increment per pass is 0/1/3/5/8 for 0/1/2/3/>=4 lines
//     undefined -> score increment per pass equals the number of lines cleared
//
//   Ports
//     clk            rising-edge clock
//     rst            asynchronous reset, active low
//     start          piece-locked pulse; accepted only while idle
//     board_in       board snapshot; row r = bits [COLS*r +: COLS]; row 0 is top
//     score_clr      synchronous score clear; takes priority over a score update
//     busy           high whenever a pass is in progress
//     done           one-cycle pulse in the final cycle of a pass
//     board_out      compacted board from the last completed pass
//     lines_cleared  rows removed in the last completed pass
//     score          running score, saturating at 99
module line_clear_ctrl #(
  parameter int ROWS = 20,
  parameter int COLS = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ROWS*COLS-1:0]          board_in,
  input  logic                          score_clr,
  output logic                          busy,
  output logic                          done,
  output logic [ROWS*COLS-1:0]          board_out,
  output logic [$clog2(ROWS+1)-1:0]     lines_cleared,
  output logic [6:0]                    score
);

  localparam int PW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = $clog2(ROWS+1);

  typedef logic [ROWS-1:0][COLS-1:0] board_t;
  typedef enum logic [2:0] {IDLE, LOAD, SCAN, SHIFT, DONE} state_t;

  state_t        state, state_nxt;
  board_t        row_buf, shifted, bout_q;
  logic [PW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic          row_full;
  logic [7:0]    inc, sum;
  logic [6:0]    score_nxt;

  assign row_full  = &row_buf[ptr];
  assign board_out = bout_q;

  // Move-down network. Rows at or above the pointer take the row above them.
  // Row 0 refills with empty cells. Rows below the pointer are kept as they are.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    if (r == 0) begin : g_top
      assign shifted[0] = '0;
    end else begin : g_mid
      assign shifted[r] = (PW'(r) <= ptr) ? row_buf[r-1] : row_buf[r];
    end
  end

  // Score increment for this pass
`ifdef LINE_CLEAR_BONUS_EN
  always_comb begin
    inc = 8'd0;
    case (cnt)
      CW'(0):  inc = 8'd0;
      CW'(1):  inc = 8'd1;
      CW'(2):  inc = 8'd3;
      CW'(3):  inc = 8'd5;
      default: inc = 8'd8;
    endcase
  end
`else
  assign inc = 8'(cnt);
`endif

  // The 8-bit sum cannot wrap: 99 + ROWS fits comfortably.
  assign sum       = {1'b0, score} + inc;
  assign score_nxt = (sum > 8'd99) ? 7'd99 : sum[6:0];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = SCAN;
      SCAN:    if (row_full)      state_nxt = SHIFT;
               else if (ptr == '0) state_nxt = DONE;
      SHIFT:   state_nxt = SCAN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_buf       <= '0;
      bout_q        <= '0;
      ptr           <= '0;
      cnt           <= '0;
      lines_cleared <= '0;
      score         <= '0;
    end else begin
      case (state)
        LOAD: begin
          row_buf <= board_in;
          ptr     <= PW'(ROWS-1);
          cnt     <= '0;
        end
        SCAN: if (!row_full && ptr != '0) ptr <= ptr - 1'b1;
        // The pointer stays put so that the row that just moved down is checked next.
        SHIFT: begin
          row_buf <= shifted;
          cnt     <= cnt + 1'b1;
        end
        DONE: begin
          bout_q        <= row_buf;
          lines_cleared <= cnt;
          score         <= score_nxt;
        end
        default: ;
      endcase
      if (score_clr) score <= '0;
    end
  end

endmodule

// File: tb/tb_line_clear_ctrl.sv
module tb_line_clear_ctrl;
  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int BW   = ROWS*COLS;

  typedef logic [ROWS-1:0][COLS-1:0] board_t;
  typedef struct {
    string  name;
    board_t b;
    board_t exp_b;
    int     exp_k;
    int     exp_score;
    int     exp_lat;
  } vec_t;

  logic          clk = 0, rst = 0, start = 0, score_clr = 0;
  logic [BW-1:0] board_in = '0;
  logic          busy, done;
  logic [BW-1:0] board_out;
  logic [4:0]    lines_cleared;
  logic [6:0]    score;

  int n_chk = 0, n_fail = 0;
  int model_score = 0;
  vec_t tbl[3];

  line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst(rst), .start(start), .board_in(board_in),
    .score_clr(score_clr), .busy(busy), .done(done), .board_out(board_out),
    .lines_cleared(lines_cleared), .score(score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int bonus(input int k);
`ifdef LINE_CLEAR_BONUS_EN
    case (k)
      0: return 0;
      1: return 1;
      2: return 3;
      3: return 5;
      default: return 8;
    endcase
`else
    return k;
`endif
  endfunction

  // Reference: keep the non-full rows in their original order and stack them at the bottom.
  function automatic void compact(input board_t b, output board_t o, output int k);
    int dst = ROWS-1;
    o = '0; k = 0;
    for (int r = ROWS-1; r >= 0; r--) begin
      if (b[r] == {COLS{1'b1}}) k++;
      else begin o[dst] = b[r]; dst--; end
    end
  endfunction

  task automatic run_pass(input string nm, input board_t b, input bit clr, input bit poke,
                          input board_t exp_b, input int exp_k, input int exp_score,
                          input int exp_lat);
    int lat = 0;
    @(negedge clk); board_in = b; start = 1;
    @(negedge clk); start = 0;
    for (int n = 1; n <= ROWS*3+10; n++) begin
      @(negedge clk);
      if (done) begin lat = n; break; end
      if (poke && n == 3) begin start = 1; board_in = '1; end
      else if (poke && n == 4) start = 0;
    end
    start = 0;
    if (lat == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s timeout: done never seen, expected after %0d edges", nm, exp_lat);
      return;
    end
    chk({nm, " latency"}, BW'(lat), BW'(exp_lat));
    chk({nm, " busy_in_done"}, BW'(busy), BW'(1));
    score_clr = clr;
    @(negedge clk); score_clr = 0;
    chk({nm, " done_pulse"}, BW'(done), BW'(0));
    chk({nm, " busy_after"}, BW'(busy), BW'(0));
    chk({nm, " board_out"}, board_out, exp_b);
    chk({nm, " lines"}, BW'(lines_cleared), BW'(exp_k));
    chk({nm, " score"}, BW'(score), BW'(exp_score));
  endtask

  task automatic run_model(input string nm, input board_t b, input bit clr, input bit poke);
    board_t eb; int k, es;
    compact(b, eb, k);
    es = model_score + bonus(k);
    if (es > 99) es = 99;
    if (clr) es = 0;
    model_score = es;
    run_pass(nm, b, clr, poke, eb, k, es, ROWS + 2*k + 1);
  endtask

  function automatic board_t full_bottom(input int k);
    board_t b = '0;
    for (int r = 0; r < k; r++) b[ROWS-1-r] = '1;
    return b;
  endfunction

  initial begin
    board_t b, b2;
    int k;

    // Directed table
    tbl[0].name = "empty"; tbl[0].b = '0; tbl[0].exp_b = '0;
    tbl[0].exp_k = 0; tbl[0].exp_score = 0; tbl[0].exp_lat = 21;
    tbl[1].name = "one_line"; tbl[1].b = '0; tbl[1].b[19] = '1; tbl[1].b[18] = 10'b0000000001;
    tbl[1].exp_b = '0; tbl[1].exp_b[19] = 10'b0000000001;
    tbl[1].exp_k = 1; tbl[1].exp_score = 1; tbl[1].exp_lat = 23;
    tbl[2].name = "four_line"; tbl[2].b = '0;
    for (int r = 16; r < 20; r++) tbl[2].b[r] = '1;
    tbl[2].b[15] = 10'b1010101010;
    tbl[2].exp_b = '0; tbl[2].exp_b[19] = 10'b1010101010;
    tbl[2].exp_k = 4; tbl[2].exp_lat = 29;
`ifdef LINE_CLEAR_BONUS_EN
    tbl[2].exp_score = 8;
`else
    tbl[2].exp_score = 4;
`endif

    #1;
    chk("reset busy", BW'(busy), BW'(0));
    chk("reset done", BW'(done), BW'(0));
    chk("reset board_out", board_out, '0);
    chk("reset lines", BW'(lines_cleared), BW'(0));
    chk("reset score", BW'(score), BW'(0));
    @(negedge clk); rst = 1;

    foreach (tbl[i]) begin
      @(negedge clk); score_clr = 1;
      @(negedge clk); score_clr = 0;
      run_pass(tbl[i].name, tbl[i].b, 0, 0, tbl[i].exp_b, tbl[i].exp_k,
               tbl[i].exp_score, tbl[i].exp_lat);
    end
    model_score = tbl[2].exp_score;

    // Every row full
    b = '1;
    run_model("all_full", b, 0, 0);

    // A full row 0 is removed like any other row
    b = '0; b[0] = '1; b[5] = 10'b1100110011;
    run_model("top_full", b, 0, 0);

    // Bring the score to 97, then exercise saturation and clear-on-DONE
    @(negedge clk); score_clr = 1;
    @(negedge clk); score_clr = 0;
    model_score = 0;
    while (model_score < 97) begin
      k = 4;
      while (bonus(k) > 97 - model_score) k--;
      run_model("preload", full_bottom(k), 0, 0);
    end
    chk("preload score", BW'(score), BW'(97));
    run_model("sat4", full_bottom(4), 0, 0);
    chk("sat score", BW'(score), BW'(99));
    run_model("sat1", full_bottom(1), 0, 0);
    run_model("clr_on_done", full_bottom(1), 1, 0);
    chk("clr lines", BW'(lines_cleared), BW'(1));

    // Randomised boards checked against the model
    for (int t = 0; t < 30; t++) begin
      for (int r = 0; r < ROWS; r++)
        case ($urandom_range(0, 2))
          0: b[r] = '1;
          1: b[r] = COLS'($urandom);
          default: b[r] = '0;
        endcase
      run_model("rand", b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a 2-line pass
    b2 = '0; b2[19] = '1; b2[18] = '1; b2[17] = 10'b0110011001;
    run_model("pre_reset", b2, 0, 0);
    @(negedge clk); board_in = b2; start = 1;
    @(negedge clk); start = 0;
    repeat (5) @(posedge clk);
    #2 rst = 0;
    #1;
    chk("midrst busy", BW'(busy), BW'(0));
    chk("midrst done", BW'(done), BW'(0));
    chk("midrst board_out", board_out, '0);
    chk("midrst lines", BW'(lines_cleared), BW'(0));
    chk("midrst score", BW'(score), BW'(0));
    model_score = 0;
    @(negedge clk); rst = 1;
    repeat (3) @(negedge clk);
    chk("post_rst idle", BW'(busy), BW'(0));
    chk("post_rst board_out", board_out, '0);
    // The extra start pulse during this pass must be ignored
    run_model("after_rst", b2, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
